// File: rtl/ucq_multi_push.sv
// Unit-clause queue with NUM_PUSH round-robin push channels and one pop port.
// Define UCQ_DEDUP_EN to drop pushes of literals already resident in the queue.
module ucq_multi_push #(
  parameter int LIT_W    = 9,
  parameter int DEPTH    = 8,
  parameter int NUM_PUSH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [NUM_PUSH-1:0]             push_valid,
  input  logic [NUM_PUSH-1:0][LIT_W-1:0]  push_lit,
  output logic [NUM_PUSH-1:0]             push_ready,
  output logic                            pop_valid,
  output logic [LIT_W-1:0]                pop_lit,
  input  logic                            pop_ready,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            full,
  output logic                            empty,
  output logic                            dup_drop
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int RR_W  = (NUM_PUSH > 1) ? $clog2(NUM_PUSH) : 1;

  logic [LIT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [RR_W-1:0]  rr_r;

  logic [PTR_W-1:0] count_s;
  logic             empty_s;
  logic             full_s;
  logic             pop_fire_s;
  logic             space_s;
  logic             grant_any_s;
  logic [RR_W-1:0]  grant_idx_s;
  logic [RR_W-1:0]  rr_next_s;
  logic             dup_s;
  logic             accept_s;
  logic             write_s;
  int               dist_s;
  int               best_dist_s;

  assign count_s    = tail_r - head_r;
  assign empty_s    = (head_r == tail_r);
  assign full_s     = (head_r[IDX_W-1:0] == tail_r[IDX_W-1:0]) &&
                      (head_r[IDX_W] != tail_r[IDX_W]);
  assign pop_fire_s = !empty_s && pop_ready && !flush;
  assign space_s    = !full_s || (!empty_s && pop_ready);

  // Round-robin pick: the valid channel with the smallest distance from rr_r wins.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = {RR_W{1'b0}};
    best_dist_s = NUM_PUSH;
    dist_s      = 0;
    for (int i = 0; i < NUM_PUSH; i++) begin
      dist_s = (i + NUM_PUSH - int'(rr_r)) % NUM_PUSH;
      if (push_valid[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        grant_idx_s = RR_W'(i);
        grant_any_s = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Next round-robin start is the channel after the granted one.
  always_comb begin
    if (int'(grant_idx_s) == NUM_PUSH - 1) begin
      rr_next_s = {RR_W{1'b0}};
    end else begin
      rr_next_s = grant_idx_s + RR_W'(1);
    end
  end

`ifdef UCQ_DEDUP_EN
  logic             match_s;
  logic [IDX_W-1:0] off_s;

  // Residency compare; the entry popped this cycle still counts as resident.
  always_comb begin
    match_s = 1'b0;
    off_s   = {IDX_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off_s = IDX_W'(i) - head_r[IDX_W-1:0];
      if (({1'b0, off_s} < count_s) && (mem_r[i] == push_lit[grant_idx_s])) begin
        match_s = 1'b1;
      end else begin
        match_s = match_s;
      end
    end
  end

  assign dup_s = grant_any_s && match_s;
`else
  assign dup_s = 1'b0;
`endif

  // A duplicate does not need space because nothing is written for it.
  assign accept_s = grant_any_s && (space_s || dup_s) && !flush;
  assign write_s  = accept_s && !dup_s;

  // Per-channel ready follows the single accepted grant.
  always_comb begin
    push_ready = {NUM_PUSH{1'b0}};
    for (int i = 0; i < NUM_PUSH; i++) begin
      if (accept_s && (int'(grant_idx_s) == i)) begin
        push_ready[i] = 1'b1;
      end else begin
        push_ready[i] = 1'b0;
      end
    end
  end

  // Pointer, arbiter and storage state; flush outranks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      rr_r   <= {RR_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {LIT_W{1'b0}};
      end
    end else if (flush) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= {PTR_W{1'b0}};
      rr_r   <= {RR_W{1'b0}};
    end else begin
      if (accept_s) begin
        rr_r <= rr_next_s;
      end
      if (write_s) begin
        mem_r[tail_r[IDX_W-1:0]] <= push_lit[grant_idx_s];
        tail_r                   <= tail_r + PTR_W'(1);
      end
      if (pop_fire_s) begin
        head_r <= head_r + PTR_W'(1);
      end
    end
  end

  assign pop_valid = !empty_s;
  assign pop_lit   = empty_s ? {LIT_W{1'b0}} : mem_r[head_r[IDX_W-1:0]];
  assign count     = count_s;
  assign full      = full_s;
  assign empty     = empty_s;
  assign dup_drop  = accept_s && dup_s;

endmodule

// File: doc/ucq_multi_push.md
# ucq_multi_push

Parametrised unit-clause queue accepting literals from several processing engines and presenting one head literal to the unit-clause arbiter. It generalises the single-port unit-clause queue with configurable depth and literal width, N push channels arbitrated round-robin, valid/ready handshakes on both sides, an occupancy count, and synchronous flush. It optionally drops literals already resident in the queue.

## Interface
- LIT_W, 9: literal width in bits (512 literals).
- DEPTH, 8: entries; power of two, at least 2.
- NUM_PUSH, 4: push channels, at least 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous clear of queue contents.
- push_valid  in  NUM_PUSH  per-channel literal offered.
- push_lit  in  NUM_PUSH x LIT_W  per-channel literal.
- push_ready  out  NUM_PUSH  per-channel accept; a transfer happens when valid && ready.
- pop_valid  out  1  head literal present (equals !empty).
- pop_lit  out  LIT_W  head literal; 0 when empty.
- pop_ready  in  1  consumer takes the head.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- dup_drop  out  1  one-cycle pulse when an accepted push is discarded as duplicate.

## Operation
- Storage: DEPTH x LIT_W array. Head and tail pointers are $clog2(DEPTH)+1 bits; low bits index, MSB is the wrap bit. Empty when the pointers are equal. Full when the index bits are equal and the MSBs differ.
- Pop: when pop_valid && pop_ready, head increments. pop_lit = entry[head index] combinationally.
- Push space: space = !full || (pop_valid && pop_ready). Push into a full queue is allowed only when a pop occurs in the same cycle.
- Arbitration: among asserted push_valid, grant the lowest index at or after rr_ptr, modulo NUM_PUSH. push_ready[i] = grant[i] && space && !flush. At most one push is accepted per cycle.
- After an accepted push by channel g, rr_ptr = (g+1) mod NUM_PUSH. rr_ptr holds otherwise.
- Accepted push writes entry[tail index] and increments tail.
- count = tail - head. It is +1 on push only, -1 on pop only, and unchanged on push+pop.
- Flush has priority over push and pop. Head, tail and rr_ptr clear to 0, and push_ready is all 0 that cycle. Array contents are don't-care.
- An empty queue never pops, and pop_ready is ignored. A pushed literal is not visible as head in the same cycle.

## Timing
- Reset values: head, tail and rr_ptr are 0, and the array is cleared to 0. Outputs after reset: pop_valid=0, pop_lit=0, count=0, full=0, empty=1, dup_drop=0, push_ready=0 unless push_valid is asserted.
- push_ready is combinational from push_valid, pop_ready, flush and state. pop_valid, pop_lit, count, full and empty depend only on registered state.
- Push-to-head latency is 1 cycle: the literal pushed in cycle t is pop_lit in cycle t+1 if the queue was empty.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 with no bubble.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

## Configuration
- UCQ_DEDUP_EN defined: the granted push_lit is compared against every valid entry.
  - On a match, push_ready is still asserted for that channel and rr_ptr advances, but nothing is written, tail and count hold, and dup_drop pulses for that cycle.
  - The entry being popped in the same cycle still counts as resident.
  - The duplicate check does not require space: a duplicate into a full queue is accepted and dropped.
- UCQ_DEDUP_EN undefined: there is no comparator, every granted push is stored, and dup_drop is tied to 0.

## Test plan
- Reset with all push_valid asserted: pop_valid=0, count=0, empty=1. After rst deasserts, channel 0 is granted first.
- Channels 0–3 each hold one valid literal (5, 6, 7, 8) over 4 cycles with no pop: grants go in order 0, 1, 2, 3. Popping then yields 5, 6, 7, 8, and count goes 4→0.
- Fill DEPTH=8, then hold push_valid[1] with pop_ready=1: one push and one pop per cycle, count stays 8, full=1, and FIFO order holds across pointer wrap for 20 cycles.
- Full queue with push_valid=1 and pop_ready=0: push_ready=0 and count stays 8. Assert flush: next cycle count=0 and empty=1.
- Empty queue with push and pop_ready both asserted: the push is accepted, count=1 next cycle, and pop_lit equals the pushed value.
- With UCQ_DEDUP_EN: push 12, then push 12 again. The second push gets push_ready=1 and dup_drop=1, and count stays 1. Without the macro, count becomes 2.
